// File: rtl/divisor_parametrizado.sv
// Programmable-modulus synchronous counter with JK-style mode control, two tapped
// square-wave outputs and single-cycle enable pulses for the panel logic.
module divisor_parametrizado #(
    parameter int LARGURA = 24,
    parameter int TAP_A   = 5,
    parameter int TAP_B   = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         modo,
    input  logic [LARGURA-1:0] divisor,
    output logic [LARGURA-1:0] contagem,
    output logic               saida1,
    output logic               saida2,
    output logic               tick,
    output logic               pulso1,
    output logic               pulso2
);

    typedef enum logic [1:0] {
        MODO_HOLD   = 2'b00,
        MODO_CLEAR  = 2'b01,
        MODO_PRESET = 2'b10,
        MODO_COUNT  = 2'b11
    } modo_t;

    // Taps outside the counter would silently read a nonexistent bit.
    if (LARGURA < 2 || LARGURA > 32) begin : gen_bad_largura
        $error("divisor_parametrizado: LARGURA must be in 2..32");
    end
    if (TAP_A < 1 || TAP_A > LARGURA) begin : gen_bad_tap_a
        $error("divisor_parametrizado: TAP_A must be in 1..LARGURA");
    end
    if (TAP_B < 1 || TAP_B > LARGURA) begin : gen_bad_tap_b
        $error("divisor_parametrizado: TAP_B must be in 1..LARGURA");
    end

    logic [LARGURA-1:0] terminal;
    logic [LARGURA-1:0] contagemNext;
    logic               tickNext;
    logic               saida1Atrasada;
    logic               saida2Atrasada;

    assign terminal = (divisor != '0) ? (divisor - LARGURA'(1)) : '1;

    always_comb begin
        contagemNext = contagem;
        tickNext     = 1'b0;
        case (modo_t'(modo))
            MODO_HOLD:   contagemNext = contagem;
            MODO_CLEAR:  contagemNext = '0;
            MODO_PRESET: contagemNext = terminal;
            MODO_COUNT: begin
                // >= so that lowering divisor below the current count still wraps.
                if (contagem >= terminal) begin
                    contagemNext = '0;
                    tickNext     = 1'b1;
                end else begin
                    contagemNext = contagem + LARGURA'(1);
                end
            end
            default: contagemNext = contagem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            contagem       <= '0;
            tick           <= 1'b0;
            saida1Atrasada <= 1'b0;
            saida2Atrasada <= 1'b0;
        end else begin
            contagem       <= contagemNext;
            tick           <= tickNext;
            saida1Atrasada <= saida1;
            saida2Atrasada <= saida2;
        end
    end

    assign saida1 = contagem[TAP_A-1];
    assign saida2 = contagem[TAP_B-1];
    assign pulso1 = saida1 & ~saida1Atrasada;
    assign pulso2 = saida2 & ~saida2Atrasada;

endmodule

// File: tb/tb_divisor_parametrizado.sv
// Directed self-checking bench for divisor_parametrizado (LARGURA=8, TAP_A=2, TAP_B=8).
module tb_divisor_parametrizado;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] modo;
    logic [7:0] divisor;
    logic [7:0] contagem;
    logic       saida1, saida2, tick, pulso1, pulso2;

    int errorCount = 0;
    int checkCount = 0;

    divisor_parametrizado #(.LARGURA(8), .TAP_A(2), .TAP_B(8)) dut (
        .clk(clk), .reset(reset), .modo(modo), .divisor(divisor),
        .contagem(contagem), .saida1(saida1), .saida2(saida2),
        .tick(tick), .pulso1(pulso1), .pulso2(pulso2)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic applyStimulus(input logic r, input logic [1:0] m,
                                 input logic [7:0] d, input int n);
        reset   = r;
        modo    = m;
        divisor = d;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int p1, p2, s1, ticks;

    initial begin
        // 1: reset then first counts
        applyStimulus(1'b1, 2'b11, 8'd0, 3);
        checkOutput("rst_cnt", 32'(contagem), 0);
        checkOutput("rst_tick", 32'(tick), 0);
        checkOutput("rst_s1", 32'(saida1), 0);
        checkOutput("rst_s2", 32'(saida2), 0);
        checkOutput("rst_p1", 32'(pulso1), 0);
        checkOutput("rst_p2", 32'(pulso2), 0);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b0, 2'b11, 8'd0, 1);
            checkOutput("rel_cnt", 32'(contagem), 32'(k));
            checkOutput("rel_tick", 32'(tick), 0);
        end

        // 2: free-run from 3 to 255, then wrap
        p1 = 0; p2 = 0; s1 = 0;
        for (int k = 0; k < 252; k++) begin
            applyStimulus(1'b0, 2'b11, 8'd0, 1);
            p1 += int'(pulso1);
            p2 += int'(pulso2);
            s1 += int'(saida1);
            if (contagem == 8'd128) begin
                checkOutput("s2_rise", 32'(saida2), 1);
                checkOutput("p2_rise", 32'(pulso2), 1);
            end
        end
        checkOutput("fr_cnt255", 32'(contagem), 255);
        checkOutput("fr_tick255", 32'(tick), 0);
        checkOutput("fr_p1count", 32'(p1), 63);
        checkOutput("fr_s1high", 32'(s1), 126);
        checkOutput("fr_p2count", 32'(p2), 1);
        applyStimulus(1'b0, 2'b11, 8'd0, 1);
        checkOutput("wrap_cnt", 32'(contagem), 0);
        checkOutput("wrap_tick", 32'(tick), 1);
        checkOutput("wrap_p2", 32'(pulso2), 0);
        applyStimulus(1'b0, 2'b11, 8'd0, 1);
        checkOutput("post_cnt", 32'(contagem), 1);
        checkOutput("post_tick", 32'(tick), 0);

        // 3: modulus 10, then modulus 1
        applyStimulus(1'b0, 2'b01, 8'd10, 1);
        checkOutput("clr_cnt", 32'(contagem), 0);
        checkOutput("clr_tick", 32'(tick), 0);
        ticks = 0;
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(1'b0, 2'b11, 8'd10, 1);
            ticks += int'(tick);
            checkOutput("m10_cnt", 32'(contagem), 32'(k % 10));
            checkOutput("m10_tick", 32'(tick), (k % 10 == 0) ? 1 : 0);
        end
        checkOutput("m10_ticks", 32'(ticks), 2);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 2'b11, 8'd1, 1);
            checkOutput("m1_cnt", 32'(contagem), 0);
            checkOutput("m1_tick", 32'(tick), 1);
        end

        // 4: mode sequence from 37
        applyStimulus(1'b0, 2'b01, 8'd0, 1);
        applyStimulus(1'b0, 2'b11, 8'd0, 37);
        checkOutput("to37", 32'(contagem), 37);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 2'b00, 8'd10, 1);
            checkOutput("hold_cnt", 32'(contagem), 37);
            checkOutput("hold_tick", 32'(tick), 0);
        end
        applyStimulus(1'b0, 2'b01, 8'd10, 1);
        checkOutput("clear_cnt", 32'(contagem), 0);
        checkOutput("clear_tick", 32'(tick), 0);
        applyStimulus(1'b0, 2'b10, 8'd10, 1);
        checkOutput("preset_cnt", 32'(contagem), 9);
        checkOutput("preset_tick", 32'(tick), 0);
        checkOutput("preset9_s1", 32'(saida1), 0);
        checkOutput("preset9_p1", 32'(pulso1), 0);
        applyStimulus(1'b0, 2'b11, 8'd10, 1);
        checkOutput("pw_cnt", 32'(contagem), 0);
        checkOutput("pw_tick", 32'(tick), 1);

        // 5: lowering the modulus below the current count
        applyStimulus(1'b0, 2'b01, 8'd10, 1);
        applyStimulus(1'b0, 2'b11, 8'd10, 7);
        checkOutput("to7", 32'(contagem), 7);
        applyStimulus(1'b0, 2'b11, 8'd4, 1);
        checkOutput("low_cnt", 32'(contagem), 0);
        checkOutput("low_tick", 32'(tick), 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 2'b11, 8'd4, 1);
            checkOutput("m4_cnt", 32'(contagem), 32'(k % 4));
            checkOutput("m4_tick", 32'(tick), (k % 4 == 0) ? 1 : 0);
        end
        applyStimulus(1'b0, 2'b01, 8'd4, 1);
        applyStimulus(1'b0, 2'b10, 8'd4, 1);
        checkOutput("preset3_cnt", 32'(contagem), 3);
        checkOutput("preset3_p1", 32'(pulso1), 1);
        checkOutput("preset3_tick", 32'(tick), 0);
        applyStimulus(1'b0, 2'b00, 8'd4, 1);
        checkOutput("hold3_p1", 32'(pulso1), 0);

        // 6: reset on the wrap edge suppresses the tick
        applyStimulus(1'b0, 2'b01, 8'd0, 1);
        applyStimulus(1'b0, 2'b11, 8'd0, 255);
        checkOutput("to255", 32'(contagem), 255);
        checkOutput("to255_s2", 32'(saida2), 1);
        applyStimulus(1'b1, 2'b11, 8'd0, 1);
        checkOutput("rw_cnt", 32'(contagem), 0);
        checkOutput("rw_tick", 32'(tick), 0);
        checkOutput("rw_p1", 32'(pulso1), 0);
        checkOutput("rw_p2", 32'(pulso2), 0);
        applyStimulus(1'b0, 2'b11, 8'd0, 1);
        checkOutput("rw_next_cnt", 32'(contagem), 1);
        checkOutput("rw_next_tick", 32'(tick), 0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
